serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, giving the operand width in bits (legal range 1..32).
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port IN_VALID, input, 1 bit: the operand set A/B/C0 is presented.
REQ-005 The block SHALL have port IN_READY, output, 1 bit: the block accepts operands this cycle.
REQ-006 The block SHALL have ports A and B, input, WIDTH bits each: the operands, unsigned.
REQ-007 The block SHALL have port C0, input, 1 bit: carry-in.
REQ-008 The block SHALL have port OUT_VALID, output, 1 bit: S/C hold a completed result.
REQ-009 The block SHALL have port OUT_READY, input, 1 bit: the consumer takes the result.
REQ-010 The block SHALL have port S, output, WIDTH bits: the sum.
REQ-011 The block SHALL have port C, output, 1 bit: carry-out.
REQ-012 The block SHALL have port BUSY, output, 1 bit: high in RUN or DONE.

Function
REQ-013 The block SHALL compute {C,S} = A + B + C0 bit-serially, LSB first, one full-adder bit slice per cycle.
- Per bit: sum = a^b^cy; cy_next = (a&b)|(b&cy)|(cy&a).
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 IDLE behaviour SHALL be:
- IN_READY=1, OUT_VALID=0.
- On IN_VALID=1 at an edge: capture A and B into shift registers, carry register <= C0, bit counter <= 0, go to RUN.
REQ-016 RUN behaviour SHALL be:
- Each edge: process the LSB of both shift registers, shift the sum bit into the S register from the MSB side (right shift), update carry, counter+1.
- On the edge where the counter reaches WIDTH-1 (WIDTH bits done): go to DONE.
REQ-017 DONE behaviour SHALL be:
- OUT_VALID=1; S and C hold the final result, stable until the handshake.
- On OUT_READY=1 at an edge: go to IDLE.
REQ-018 Latency SHALL be exactly WIDTH cycles: acceptance on edge k makes OUT_VALID rise after edge k+WIDTH.
REQ-019 The block SHALL accept no new operand while BUSY: IN_READY=0 in RUN and DONE, and IN_VALID is ignored there.
- After each result handshake there is one IDLE cycle before the next acceptance.
REQ-020 OUT_READY SHALL be ignored outside DONE.
REQ-021 A/B/C0 changes after acceptance SHALL NOT affect the result in progress.
REQ-022 The result width SHALL be exactly WIDTH+1 bits; overflow beyond that is impossible, and C carries bit WIDTH.
REQ-023 S and C SHALL retain their last result in IDLE until the next acceptance overwrites the S register during RUN.
REQ-024 For WIDTH=1, RUN SHALL last one cycle.

Reset
REQ-025 RST_N=0 SHALL immediately, without a clock, force: state IDLE, S=0, C=0, OUT_VALID=0, BUSY=0, shift registers, carry and counter =0.
- IN_READY follows as 1 once in IDLE.
REQ-026 Reset asserted mid-RUN or in DONE SHALL abandon the operation; no result is emitted after reset release.
REQ-027 After RST_N rises, the first acceptance SHALL be possible on the first rising CLK edge.

Verification
REQ-028 The bench SHALL cover: WIDTH=3, A=3, B=5, C0=0, OUT_READY=1 -> OUT_VALID exactly 3 cycles after acceptance, S=000, C=1.
REQ-029 The bench SHALL cover: A=2, B=1, C0=1 -> S=100, C=0; then A=7, B=7, C0=1 -> S=111, C=1.
REQ-030 The bench SHALL cover: OUT_READY held 0 for 5 cycles in DONE -> S/C/OUT_VALID stable, IN_READY=0, and IN_VALID pulses ignored.
REQ-031 The bench SHALL cover: RST_N pulsed low after 1 RUN cycle -> all outputs 0 asynchronously; a new A=1, B=1, C0=0 afterwards -> S=010, C=0.
REQ-032 The bench SHALL cover: exhaustive WIDTH=3 sweep (all A, B, C0) plus random WIDTH=8 with random OUT_READY stalls -> every {C,S} equals A+B+C0, one result per acceptance.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder with valid/ready handshakes: {C,S} = A + B + C0, one
// full-adder slice per cycle, LSB first, through an IDLE/RUN/DONE controller.
module serial_adder_ctrl #(
   parameter int WIDTH = 3
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C0,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] S,
   output logic             C,
   output logic             BUSY
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

   localparam int CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

   stateT            state, nextState;
   logic [WIDTH-1:0] aShift, bShift, sReg, sNext;
   logic             carry, cOut;
   logic [CntW-1:0]  bitCnt;
   logic             sumBit, carryNext;

   assign sumBit    = aShift[0] ^ bShift[0] ^ carry;
   assign carryNext = (aShift[0] & bShift[0]) | (bShift[0] & carry) | (carry & aShift[0]);

   // Sum bits enter from the MSB side so the word is aligned after WIDTH shifts.
   generate
      if (WIDTH == 1) begin : gSingle
         assign sNext = sumBit;
      end else begin : gMulti
         assign sNext = {sumBit, sReg[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
      end else begin
         // NOTE: non-blocking assignments for every register so all flops
         // sample pre-edge values, independent of statement order.
         state <= nextState;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first; a missed
      // branch would otherwise infer a latch.
      nextState = state;
      IN_READY  = 1'b0;
      OUT_VALID = 1'b0;
      BUSY      = 1'b0;
      unique case (state)
         IDLE: begin
            IN_READY = 1'b1;
            if (IN_VALID) nextState = RUN;
         end
         RUN: begin
            BUSY = 1'b1;
            if (bitCnt == LastBit) nextState = DONE;
         end
         DONE: begin
            BUSY      = 1'b1;
            OUT_VALID = 1'b1;
            if (OUT_READY) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   // C lives in its own register so the visible carry-out survives the
   // carry-in load at the next acceptance.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         // NOTE: datapath registers are plain flops, not memories, so all of
         // them clear asynchronously with the state.
         aShift <= '0;
         bShift <= '0;
         sReg   <= '0;
         carry  <= 1'b0;
         cOut   <= 1'b0;
         bitCnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (IN_VALID) begin
                  aShift <= A;
                  bShift <= B;
                  carry  <= C0;
                  bitCnt <= '0;
               end
            end
            RUN: begin
               aShift <= aShift >> 1;
               bShift <= bShift >> 1;
               sReg   <= sNext;
               carry  <= carryNext;
               bitCnt <= bitCnt + CntW'(1);
               if (bitCnt == LastBit) cOut <= carryNext;
            end
            default: ;
         endcase
      end
   end

   assign S = sReg;
   assign C = cOut;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: a WIDTH=3 instance for directed and
// exhaustive vectors, a WIDTH=8 instance for random operands with output stalls.
module tb_serial_adder_ctrl;

   logic clk = 1'b0;
   logic rstN;
   int   cycleCnt = 0;
   int   nChecks  = 0;
   int   nFails   = 0;

   logic       inValid3, inReady3, c03, outValid3, outReady3, c3, busy3;
   logic [2:0] a3, b3, s3;
   logic       inValid8, inReady8, c08, outValid8, outReady8, c8, busy8;
   logic [7:0] a8, b8, s8;

   logic [3:0] exp3Q[$];
   logic [8:0] exp8Q[$];
   int         acc3Q[$];
   int         acc8Q[$];
   logic       prevValid3, prevValid8;
   logic       stallEn = 1'b0;

   serial_adder_ctrl #(.WIDTH(3)) dut3 (
      .CLK(clk), .RST_N(rstN), .IN_VALID(inValid3), .IN_READY(inReady3),
      .A(a3), .B(b3), .C0(c03), .OUT_VALID(outValid3), .OUT_READY(outReady3),
      .S(s3), .C(c3), .BUSY(busy3)
   );

   serial_adder_ctrl #(.WIDTH(8)) dut8 (
      .CLK(clk), .RST_N(rstN), .IN_VALID(inValid8), .IN_READY(inReady8),
      .A(a8), .B(b8), .C0(c08), .OUT_VALID(outValid8), .OUT_READY(outReady8),
      .S(s8), .C(c8), .BUSY(busy8)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitors: sample at the falling edge, where inputs and outputs both show
   // what the next rising edge will act on.
   always @(negedge clk) begin
      if (!rstN) begin
         prevValid3 = 1'b0;
      end else begin
         if (outValid3 && !prevValid3) begin
            if (acc3Q.size() == 0) check("valid3_without_accept", 32'(outValid3), 32'd0);
            else check("latency3", cycleCnt - acc3Q.pop_front(), 32'd3);
         end
         if (outValid3 && outReady3) begin
            if (exp3Q.size() == 0) check("result3_without_accept", 32'(outValid3), 32'd0);
            else check("sum3", 32'({c3, s3}), 32'(exp3Q.pop_front()));
         end
         prevValid3 = outValid3;
      end
   end

   always @(negedge clk) begin
      if (!rstN) begin
         prevValid8 = 1'b0;
      end else begin
         if (outValid8 && !prevValid8) begin
            if (acc8Q.size() == 0) check("valid8_without_accept", 32'(outValid8), 32'd0);
            else check("latency8", cycleCnt - acc8Q.pop_front(), 32'd8);
         end
         if (outValid8 && outReady8) begin
            if (exp8Q.size() == 0) check("result8_without_accept", 32'(outValid8), 32'd0);
            else check("sum8", 32'({c8, s8}), 32'(exp8Q.pop_front()));
         end
         prevValid8 = outValid8;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         outReady8 = stallEn ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   // Holds IN_VALID until the DUT is ready, then scrambles operands afterwards
   // so a result depending on post-acceptance inputs gets caught.
   task automatic send3(input int a, input int b, input int c0);
      bit done = 0;
      @(posedge clk);
      #1;
      a3 = 3'(a); b3 = 3'(b); c03 = 1'(c0); inValid3 = 1'b1;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk);
         if (inReady3) begin
            exp3Q.push_back(4'(a + b + c0));
            acc3Q.push_back(cycleCnt + 1);
            done = 1;
         end
      end
      if (!done) check("accept3_timeout", 32'(inReady3), 32'd1);
      @(posedge clk);
      #1;
      inValid3 = 1'b0;
      a3 = 3'($urandom); b3 = 3'($urandom); c03 = 1'($urandom);
   endtask

   task automatic send8(input int a, input int b, input int c0);
      bit done = 0;
      @(posedge clk);
      #1;
      a8 = 8'(a); b8 = 8'(b); c08 = 1'(c0); inValid8 = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (inReady8) begin
            exp8Q.push_back(9'(a + b + c0));
            acc8Q.push_back(cycleCnt + 1);
            done = 1;
         end
      end
      if (!done) check("accept8_timeout", 32'(inReady8), 32'd1);
      @(posedge clk);
      #1;
      inValid8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); c08 = 1'($urandom);
   endtask

   task automatic drain3();
      for (int i = 0; i < 100 && exp3Q.size() != 0; i++) @(negedge clk);
      check("drain3", exp3Q.size(), 32'd0);
   endtask

   task automatic drain8();
      for (int i = 0; i < 2000 && exp8Q.size() != 0; i++) @(negedge clk);
      check("drain8", exp8Q.size(), 32'd0);
   endtask

   initial begin
      rstN = 1'b0;
      inValid3 = 1'b0; a3 = '0; b3 = '0; c03 = 1'b0; outReady3 = 1'b1;
      inValid8 = 1'b0; a8 = '0; b8 = '0; c08 = 1'b0;
      #3;
      check("rst_in_ready", 32'(inReady3), 32'd1);
      check("rst_out_valid", 32'(outValid3), 32'd0);
      check("rst_s", 32'(s3), 32'd0);
      check("rst_c", 32'(c3), 32'd0);
      check("rst_busy", 32'(busy3), 32'd0);
      repeat (2) @(negedge clk);
      rstN = 1'b1;

      // Directed vectors.
      send3(3, 5, 0);
      send3(2, 1, 1);
      send3(7, 7, 1);
      drain3();

      // Result held in DONE while the consumer stalls.
      @(posedge clk);
      #1;
      outReady3 = 1'b0;
      send3(6, 3, 0);
      for (int i = 0; i < 20 && !outValid3; i++) @(negedge clk);
      check("stall_valid_rise", 32'(outValid3), 32'd1);
      repeat (5) begin
         @(posedge clk);
         #1;
         inValid3 = 1'b1; a3 = 3'd1; b3 = 3'd1; c03 = 1'b1;
         @(negedge clk);
         check("stall_out_valid", 32'(outValid3), 32'd1);
         check("stall_s", 32'(s3), 32'd1);
         check("stall_c", 32'(c3), 32'd1);
         check("stall_in_ready", 32'(inReady3), 32'd0);
         check("stall_busy", 32'(busy3), 32'd1);
      end
      @(posedge clk);
      #1;
      inValid3 = 1'b0;
      outReady3 = 1'b1;
      drain3();
      repeat (2) @(negedge clk);
      check("idle_keep_s", 32'(s3), 32'd1);
      check("idle_keep_c", 32'(c3), 32'd1);
      check("idle_out_valid", 32'(outValid3), 32'd0);

      // Reset one cycle into RUN abandons the operation.
      send3(5, 2, 0);
      @(posedge clk);
      #3;
      rstN = 1'b0;
      exp3Q.delete();
      acc3Q.delete();
      #1;
      check("midrun_rst_s", 32'(s3), 32'd0);
      check("midrun_rst_c", 32'(c3), 32'd0);
      check("midrun_rst_out_valid", 32'(outValid3), 32'd0);
      check("midrun_rst_busy", 32'(busy3), 32'd0);
      check("midrun_rst_in_ready", 32'(inReady3), 32'd1);
      repeat (2) @(negedge clk);
      rstN = 1'b1;
      repeat (8) @(negedge clk);
      check("post_rst_quiet", 32'(outValid3), 32'd0);
      send3(1, 1, 0);
      drain3();

      // Exhaustive WIDTH=3 sweep.
      for (int a = 0; a < 8; a++)
         for (int b = 0; b < 8; b++)
            for (int c0 = 0; c0 < 2; c0++)
               send3(a, b, c0);
      drain3();

      // WIDTH=8: boundaries then random operands with output stalls.
      stallEn = 1'b1;
      send8(255, 255, 1);
      send8(0, 0, 0);
      send8(255, 0, 1);
      for (int i = 0; i < 120; i++)
         send8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 1)));
      drain8();
      check("acc3_empty", acc3Q.size(), 32'd0);
      check("acc8_empty", acc8Q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
